mux_arb_n: RTL and testbench
============================

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (>=2).
REQ-003 Parameter MODE, default 0, channel-selection mode: 0 = external select, 1 = round-robin, 2 = fixed priority (lowest index wins).
REQ-004 Local constant SW = clog2(N), select/channel-index width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  per-channel valid.
REQ-009 in_ready  output  N  per-channel ready; one-hot or zero.
REQ-010 sel  input  SW  channel select; used only when MODE=0.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out_data holds an untaken word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-015 The output register shall be one entry deep; load_en = !out_valid || out_ready.
REQ-016 The grant shall be computed combinationally each cycle: MODE 0 -> channel sel, if in_valid[sel]; MODE 1 -> first valid channel searching upward from rr_ptr+1 modulo N; MODE 2 -> lowest-index valid channel.
REQ-017 in_ready[i] shall be high only when load_en, a grant exists, and i equals the granted index.
REQ-018 A transfer on channel i shall occur when in_valid[i] && in_ready[i]; on that edge out_data <= channel i data, out_ch <= i, out_valid <= 1.
REQ-019 Latency from input transfer to out_valid shall be exactly 1 cycle; sustained throughput shall be 1 word/cycle when out_ready is held high.
REQ-020 If out_valid && out_ready with no input transfer, out_valid shall go 0 on the next edge; out_data and out_ch shall retain their last values.
REQ-021 While out_valid && !out_ready, out_data, out_ch and out_valid shall be held stable and all in_ready bits shall be 0.
REQ-022 In MODE 1, rr_ptr shall update to the granted index only on a transfer, wrapping from N-1 to 0.
REQ-023 In MODE 0, an out-of-range sel (>= N when N is not a power of two) shall produce no grant.
REQ-024 A change of sel or in_valid during a stall shall not affect the held output word.
REQ-025 Simultaneous out-consume and in-transfer on the same edge shall replace the word with no bubble.

Reset
REQ-026 On rst_n low, asynchronously: out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = N-1 (channel 0 first in round-robin).
REQ-027 While rst_n is low, in_ready shall be all zeros.
REQ-028 Reset asserted mid-transfer shall discard the held word; the first grant after release shall follow REQ-016 using reset state.

Structure
REQ-029 Mode constants (MODE_SEL=0, MODE_RR=1, MODE_PRI=2) and the clog2 function shall live in the shared package mux_arb_pkg.
REQ-030 Round-robin and priority grant logic shall be one sub-module, arb_n (parameter N, MODE; inputs req, ptr; outputs gnt_valid, gnt_idx).
REQ-031 The output register and handshake shall reside in mux_arb_n; no other sub-modules.

Verification
REQ-032 MODE 0, N=4, WIDTH=32: ch0=0x0, ch1=0x1, all valid, out_ready=1, sel=0 then sel=1 -> out_data 0x0 (out_ch 0), then 0x1 (out_ch 1) one cycle after each select.
REQ-033 MODE 1, all 4 channels valid, data i = 0xA0+i, out_ready=1 -> out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0 (wrap), one per cycle.
REQ-034 MODE 2, in_valid=4'b1010 -> out_ch=1 repeatedly; drop in_valid[1] -> out_ch=3.
REQ-035 Any mode, word 0x1234 loaded, out_ready=0 for 5 cycles while inputs change -> out_data stays 0x1234, in_ready=0; out_ready=1 -> next word appears next cycle.
REQ-036 MODE 1, assert rst_n=0 while out_valid=1 -> out_valid, out_data, out_ch go 0 immediately; after release with all valid, first out_ch=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-channel output multiplexer/arbiter.
// Every file in this slice imports it.
package mux_arb_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
  localparam int MODE_PRI = 2;

  // Returns ceil(log2(value)), clamped to at least 1 bit so that a
  // channel index always has a width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int w = value - 1; w > 0; w = w >> 1) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Channel-side and output-side handshake bundle for mux_arb_n.
// The design uses the slave modport and the driver uses the master modport.
interface mux_arb_n_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
);

  localparam int SW = clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SW-1:0]      sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_ch;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/mux_arb_n_arb.sv
// Round-robin and fixed-priority grant logic for mux_arb_n.
// The result is purely combinational.
module arb_n
  import mux_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic                  gnt_valid,
  output logic [clog2(N)-1:0]   gnt_idx
);

  localparam int SW = clog2(N);

  int start;
  int cand;

  // Fixed priority is a round-robin search anchored just below channel 0.
  // Scanning from the far end lets the nearest requester be written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    start     = (MODE == MODE_RR) ? int'(ptr) : N - 1;
    for (int k = N; k >= 1; k--) begin
      cand = (start + k) % N;
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel to one multiplexer with a single-entry registered output stage.
// The channel is chosen by an external select, round-robin, or fixed priority.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MODE_SEL
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_arb_n_if.slave  bus
);

  localparam int SW = clog2(N);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SW-1:0]    outCh_q, outCh_d;
  logic             outValid_q, outValid_d;
  logic [SW-1:0]    rrPtr_q, rrPtr_d;

  logic             arbValid;
  logic [SW-1:0]    arbIdx;
  logic             gntValid;
  logic [SW-1:0]    gntIdx;
  logic             loadEn;
  logic             xfer;

  arb_n #(
    .N    (N),
    .MODE (MODE)
  ) uArb (
    .req       (bus.in_valid),
    .ptr       (rrPtr_q),
    .gnt_valid (arbValid),
    .gnt_idx   (arbIdx)
  );

  // An out-of-range select yields no grant.
  // Reset forces the ready vector to zero.
  always_comb begin
    gntValid = arbValid;
    gntIdx   = arbIdx;
    if (MODE == MODE_SEL) begin
      gntValid = 1'b0;
      gntIdx   = bus.sel;
      if (int'(bus.sel) < N) begin
        gntValid = bus.in_valid[bus.sel];
      end
    end
    loadEn       = !outValid_q || bus.out_ready;
    xfer         = rst_n && loadEn && gntValid;
    bus.in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << gntIdx) : '0;
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    rrPtr_d    = rrPtr_q;
    if (xfer) begin
      outValid_d = 1'b1;
      outData_d  = bus.in_data[gntIdx*WIDTH +: WIDTH];
      outCh_d    = gntIdx;
      if (MODE == MODE_RR) begin
        rrPtr_d = gntIdx;
      end
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // The pointer resets to N-1 so that channel 0 is first in round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
      rrPtr_q    <= SW'(N - 1);
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_ch    = outCh_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Randomized bench for mux_arb_n with four instances (select, round-robin,
// priority, and select with N=3), each checked against a queue-free model.
module tb_mux_arb_n;
  import mux_arb_pkg::*;

  localparam int NI = 4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_arb_n_if #(.WIDTH(32), .N(4)) bus0 ();
  mux_arb_n_if #(.WIDTH(32), .N(4)) bus1 ();
  mux_arb_n_if #(.WIDTH(32), .N(4)) bus2 ();
  mux_arb_n_if #(.WIDTH(8),  .N(3)) bus3 ();

  mux_arb_n #(.WIDTH(32), .N(4), .MODE(MODE_SEL)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mux_arb_n #(.WIDTH(32), .N(4), .MODE(MODE_RR))  u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mux_arb_n #(.WIDTH(32), .N(4), .MODE(MODE_PRI)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  mux_arb_n #(.WIDTH(8),  .N(3), .MODE(MODE_SEL)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int          instMode [NI] = '{MODE_SEL, MODE_RR, MODE_PRI, MODE_SEL};
  int          instN    [NI] = '{4, 4, 4, 3};
  logic [31:0] instMask [NI] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

  logic [31:0] inD    [NI][4];
  logic [3:0]  inV    [NI];
  int          inSel  [NI];
  logic        outRdy [NI];

  logic        mValid [NI];
  logic [31:0] mData  [NI];
  int          mCh    [NI];
  int          mPtr   [NI];

  int testCount;
  int failCount;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expGrant(input int mode, input int n, input logic [3:0] v, input int s, input int ptr);
    if (mode == MODE_SEL) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (mode == MODE_RR) ? (ptr + k) % n : k - 1;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mValid[i] = 1'b0;
      mData[i]  = '0;
      mCh[i]    = 0;
      mPtr[i]   = instN[i] - 1;
    end
  endtask

  task automatic drive();
    bus0.in_data   = {inD[0][3], inD[0][2], inD[0][1], inD[0][0]};
    bus0.in_valid  = inV[0];
    bus0.sel       = 2'(inSel[0]);
    bus0.out_ready = outRdy[0];
    bus1.in_data   = {inD[1][3], inD[1][2], inD[1][1], inD[1][0]};
    bus1.in_valid  = inV[1];
    bus1.sel       = 2'(inSel[1]);
    bus1.out_ready = outRdy[1];
    bus2.in_data   = {inD[2][3], inD[2][2], inD[2][1], inD[2][0]};
    bus2.in_valid  = inV[2];
    bus2.sel       = 2'(inSel[2]);
    bus2.out_ready = outRdy[2];
    bus3.in_data   = {inD[3][2][7:0], inD[3][1][7:0], inD[3][0][7:0]};
    bus3.in_valid  = inV[3][2:0];
    bus3.sel       = 2'(inSel[3]);
    bus3.out_ready = outRdy[3];
  endtask

  // Opening cycles and the cycles after the mid-run reset use all-valid
  // traffic with a free-running consumer; a regular stall window follows.
  task automatic applyStimulus(input int cyc);
    bit directed;
    directed = (cyc < 12) || (cyc >= 700 && cyc < 712);
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 4; c++) inD[i][c] = $urandom & instMask[i];
      if (directed) begin
        inV[i]    = 4'hF;
        inSel[i]  = (cyc / 2) % 4;
        outRdy[i] = 1'b1;
      end else begin
        inV[i]    = 4'($urandom);
        inSel[i]  = $urandom_range(0, 3);
        outRdy[i] = ($urandom_range(0, 3) != 0);
        if (cyc % 40 >= 30 && cyc % 40 < 36) outRdy[i] = 1'b0;
      end
      if (instN[i] == 3) inV[i][3] = 1'b0;
    end
  endtask

  task automatic readObs(input int i, output logic [31:0] d, output logic v, output int ch, output logic [3:0] rdy);
    case (i)
      0: begin d = bus0.out_data; v = bus0.out_valid; ch = int'(bus0.out_ch); rdy = bus0.in_ready; end
      1: begin d = bus1.out_data; v = bus1.out_valid; ch = int'(bus1.out_ch); rdy = bus1.in_ready; end
      2: begin d = bus2.out_data; v = bus2.out_valid; ch = int'(bus2.out_ch); rdy = bus2.in_ready; end
      default: begin
        d = {24'b0, bus3.out_data}; v = bus3.out_valid; ch = int'(bus3.out_ch); rdy = {1'b0, bus3.in_ready};
      end
    endcase
  endtask

  task automatic checkAll();
    logic [31:0] d;
    logic        v;
    int          ch;
    logic [3:0]  rdy;
    logic [3:0]  expRdy;
    int          g;
    bit          loadEn;
    for (int i = 0; i < NI; i++) begin
      readObs(i, d, v, ch, rdy);
      loadEn = !mValid[i] || outRdy[i];
      g      = expGrant(instMode[i], instN[i], inV[i], inSel[i], mPtr[i]);
      expRdy = (rst_n && loadEn && g >= 0) ? (4'b0001 << g) : 4'b0000;
      checkOutput($sformatf("u%0d in_ready", i), 64'(rdy), 64'(expRdy));
      checkOutput($sformatf("u%0d out_valid", i), 64'(v), 64'(mValid[i]));
      checkOutput($sformatf("u%0d out_data", i), 64'(d), 64'(mData[i]));
      checkOutput($sformatf("u%0d out_ch", i), 64'(ch), 64'(mCh[i]));
    end
  endtask

  task automatic modelStep();
    int g;
    for (int i = 0; i < NI; i++) begin
      g = expGrant(instMode[i], instN[i], inV[i], inSel[i], mPtr[i]);
      if ((!mValid[i] || outRdy[i]) && g >= 0) begin
        mValid[i] = 1'b1;
        mData[i]  = inD[i][g];
        mCh[i]    = g;
        if (instMode[i] == MODE_RR) mPtr[i] = g;
      end else if (outRdy[i]) begin
        mValid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 4; c++) inD[i][c] = '0;
      inV[i]    = '0;
      inSel[i]  = 0;
      outRdy[i] = 1'b0;
    end
    drive();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) begin
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus(cyc);
      drive();
      #1;
      checkAll();
      modelStep();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
